// File: rtl/bcd_calculator.sv
// Two-operand BCD push-button calculator with a scanned 4-digit
// active-low seven-segment display and a direct binary result output.
module bcd_calculator #(
  parameter int REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        B1,
  input  logic        B2,
  input  logic        B3,
  input  logic        B4,
  input  logic        B5,
  input  logic        B6,
  input  logic        B7,
  input  logic        B8,
  input  logic        B9,
  output logic [0:3]  en,
  output logic [0:6]  seg,
  output logic [0:3]  one,
  output logic [0:3]  two,
  output logic [0:3]  three,
  output logic [0:3]  four,
  output logic        dot,
  output logic [0:15] result
);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_t;

  // Step a BCD digit, wrapping 9 back to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Shift-add-3 conversion; the result never exceeds 9999 so four digits suffice.
  function automatic logic [15:0] bin_to_bcd(input logic [15:0] bin);
    logic [15:0] bcd;
    bcd = 16'd0;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  logic [8:0]              w_btn;
  logic [8:0]              r_sync1, r_sync2, r_prev;
  logic [8:0]              w_press;
  logic [3:0]              r_one, r_two, r_three, r_four;
  op_t                     r_op;
  logic [15:0]             w_a, w_b;
  logic [15:0]             w_res_nx;
  logic                    w_neg_nx, w_dz_nx;
  logic [15:0]             r_result;
  logic                    r_neg, r_divzero;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [1:0]              w_slot;
  logic [15:0]             w_res_bcd;
  logic [3:0]              w_digit;

  assign w_btn   = {B9, B8, B7, B6, B5, B4, B3, B2, B1};
  assign w_press = r_sync2 & ~r_prev;

  // Two-stage synchronizer plus previous-value register for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 9'd0;
      r_sync2 <= 9'd0;
      r_prev  <= 9'd0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Digit and operation registers; clear beats every other press in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_one   <= 4'd0;
      r_two   <= 4'd0;
      r_three <= 4'd0;
      r_four  <= 4'd0;
      r_op    <= OP_NONE;
    end else if (w_press[8]) begin
      r_one   <= 4'd0;
      r_two   <= 4'd0;
      r_three <= 4'd0;
      r_four  <= 4'd0;
      r_op    <= OP_NONE;
    end else begin
      if (w_press[0]) r_one   <= bcd_inc(r_one);
      if (w_press[1]) r_two   <= bcd_inc(r_two);
      if (w_press[2]) r_three <= bcd_inc(r_three);
      if (w_press[3]) r_four  <= bcd_inc(r_four);
      if (w_press[4])      r_op <= OP_ADD;
      else if (w_press[5]) r_op <= OP_SUB;
      else if (w_press[6]) r_op <= OP_MUL;
      else if (w_press[7]) r_op <= OP_DIV;
    end
  end

  assign w_a = {12'd0, r_one}   * 16'd10 + {12'd0, r_two};
  assign w_b = {12'd0, r_three} * 16'd10 + {12'd0, r_four};

  // Next result from the current operands; SUB reports magnitude plus a sign flag.
  always_comb begin
    w_res_nx = 16'd0;
    w_neg_nx = 1'b0;
    w_dz_nx  = 1'b0;
    case (r_op)
      OP_ADD: w_res_nx = w_a + w_b;
      OP_SUB: begin
        if (w_a < w_b) begin
          w_res_nx = w_b - w_a;
          w_neg_nx = 1'b1;
        end else begin
          w_res_nx = w_a - w_b;
        end
      end
      OP_MUL: w_res_nx = w_a * w_b;
      OP_DIV: begin
        if (w_b == 16'd0) w_dz_nx  = 1'b1;
        else              w_res_nx = w_a / w_b;
      end
      default: w_res_nx = 16'd0;
    endcase
  end

  // Result register refreshed every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= 16'd0;
      r_neg     <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_result  <= w_res_nx;
      r_neg     <= w_neg_nx;
      r_divzero <= w_dz_nx;
    end
  end

  // Free-running scan counter; its top two bits pick the active digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_refresh <= '0;
    else     r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  end

  assign w_slot    = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_res_bcd = bin_to_bcd(r_result);

  // Digit source and enable for the scanned position (slot 0 is leftmost).
  always_comb begin
    w_digit = 4'd0;
    en      = 4'b1111;
    case (w_slot)
      2'd0: begin en = 4'b0111; w_digit = (r_op == OP_NONE) ? r_one   : w_res_bcd[15:12]; end
      2'd1: begin en = 4'b1011; w_digit = (r_op == OP_NONE) ? r_two   : w_res_bcd[11:8];  end
      2'd2: begin en = 4'b1101; w_digit = (r_op == OP_NONE) ? r_three : w_res_bcd[7:4];   end
      2'd3: begin en = 4'b1110; w_digit = (r_op == OP_NONE) ? r_four  : w_res_bcd[3:0];   end
      default: begin en = 4'b1111; w_digit = 4'd0; end
    endcase
  end

  // Segment decode; divide-by-zero blanks every digit to a dash.
  always_comb begin
    seg = 7'b1111111;
    if (r_divzero) begin
      seg = 7'b1111110;
    end else begin
      case (w_digit)
        4'd0: seg = 7'b0000001;
        4'd1: seg = 7'b1001111;
        4'd2: seg = 7'b0010010;
        4'd3: seg = 7'b0000110;
        4'd4: seg = 7'b1001100;
        4'd5: seg = 7'b0100100;
        4'd6: seg = 7'b0100000;
        4'd7: seg = 7'b0001111;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0000100;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign dot    = (w_slot == 2'd0 && r_neg) ? 1'b0 : 1'b1;
  assign one    = r_one;
  assign two    = r_two;
  assign three  = r_three;
  assign four   = r_four;
  assign result = r_result;

endmodule

// File: tb/tb_bcd_calculator.sv
// Directed self-checking bench for bcd_calculator (short scan counter).
module tb_bcd_calculator;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  btn;
  logic [3:0]  en;
  logic [6:0]  seg;
  logic [3:0]  one, two, three, four;
  logic        dot;
  logic [15:0] result;
  logic [3:0]  tb_cnt;
  logic [11:0] exp_v;
  int          checks = 0;
  int          passes = 0;

  localparam logic [8:0] P_B1 = 9'h001, P_B2 = 9'h002, P_B3 = 9'h004, P_B4 = 9'h008;
  localparam logic [8:0] P_B5 = 9'h010, P_B6 = 9'h020, P_B7 = 9'h040, P_B8 = 9'h080;
  localparam logic [8:0] P_B9 = 9'h100;

  bcd_calculator #(.REFRESH_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .B1(btn[0]), .B2(btn[1]), .B3(btn[2]), .B4(btn[3]), .B5(btn[4]),
    .B6(btn[5]), .B7(btn[6]), .B8(btn[7]), .B9(btn[8]),
    .en(en), .seg(seg), .one(one), .two(two), .three(three), .four(four),
    .dot(dot), .result(result)
  );

  always #5 clk = ~clk;

  // Reference scan position: cleared by reset, advances every clock.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 4'd0;
    else     tb_cnt <= tb_cnt + 4'd1;
  end

  // Expected {en, seg, dot} for a scan slot; digs holds digits leftmost first.
  function automatic logic [11:0] exp_scan(input logic [1:0] slot, input logic [15:0] digs,
                                           input logic dash, input logic neg);
    logic [3:0] e;
    logic [3:0] d;
    logic [6:0] s;
    e = 4'b1111;
    e[3 - int'(slot)] = 1'b0;
    d = digs[4*(3 - int'(slot)) +: 4];
    case (d)
      4'd0: s = 7'b0000001;  4'd1: s = 7'b1001111;  4'd2: s = 7'b0010010;
      4'd3: s = 7'b0000110;  4'd4: s = 7'b1001100;  4'd5: s = 7'b0100100;
      4'd6: s = 7'b0100000;  4'd7: s = 7'b0001111;  4'd8: s = 7'b0000000;
      4'd9: s = 7'b0000100;  default: s = 7'b1111111;
    endcase
    if (dash) s = 7'b1111110;
    return {e, s, (slot == 2'd0 && neg) ? 1'b0 : 1'b1};
  endfunction

  // Pulse the masked buttons n times, leaving time for the result to settle.
  task automatic press(input logic [8:0] mask, input int n);
    for (int p = 0; p < n; p++) begin
      @(negedge clk); btn = mask;
      @(negedge clk); btn = 9'd0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 9'd0;
    #12;
    checks++;
    if ({en, seg, dot} !== {4'b0111, 7'b0000001, 1'b1})
      $display("FAIL reset_display: got %b expected %b", {en, seg, dot}, {4'b0111, 7'b0000001, 1'b1});
    else passes++;
    checks++;
    if ({one, two, three, four, result} !== 32'd0)
      $display("FAIL reset_regs: got %h expected 0", {one, two, three, four, result});
    else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_digit_wrap();
    for (int i = 1; i <= 11; i++) begin
      press(P_B1, 1);
      checks++;
      if (one !== 4'(i % 10)) $display("FAIL wrap_one press %0d: got %0d expected %0d", i, one, i % 10);
      else passes++;
    end
    checks++;
    if ({two, three, four, result} !== 28'd0)
      $display("FAIL wrap_others: got %h expected 0", {two, three, four, result});
    else passes++;
  endtask

  task automatic test_add();
    press(P_B2 | P_B3 | P_B4, 2);
    press(P_B3 | P_B4, 1);
    press(P_B4, 1);
    checks++;
    if ({one, two, three, four} !== 16'h1234)
      $display("FAIL add_digits: got %h expected 1234", {one, two, three, four});
    else passes++;
    @(negedge clk); btn = P_B5;
    @(negedge clk); btn = 9'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result !== 16'd0) $display("FAIL add_early: got %0d expected 0", result);
    else passes++;
    @(negedge clk);
    checks++;
    if (result !== 16'd46) $display("FAIL add_latency: got %0d expected 46", result);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h0046, 1'b0, 1'b0);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL add_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
  endtask

  task automatic test_sub_mul();
    press(P_B6, 1);
    checks++;
    if (result !== 16'd22) $display("FAIL sub_result: got %0d expected 22", result);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h0022, 1'b0, 1'b1);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL sub_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
    press(P_B7, 1);
    checks++;
    if (result !== 16'd408) $display("FAIL mul_result: got %0d expected 408", result);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h0408, 1'b0, 1'b0);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL mul_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
  endtask

  task automatic test_mul_div();
    press(P_B9, 1);
    press(P_B1 | P_B2 | P_B3 | P_B4, 9);
    press(P_B7, 1);
    checks++;
    if (result !== 16'd9801) $display("FAIL mul99_result: got %0d expected 9801", result);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h9801, 1'b0, 1'b0);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL mul99_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
    press(P_B8, 1);
    checks++;
    if (result !== 16'd1) $display("FAIL div_result: got %0d expected 1", result);
    else passes++;
    press(P_B3 | P_B4, 1);
    checks++;
    if ({one, two, three, four, result} !== {16'h9900, 16'd0})
      $display("FAIL divzero_regs: got %h expected 99000000", {one, two, three, four, result});
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h0000, 1'b1, 1'b0);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL divzero_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
  endtask

  task automatic test_clear_priority();
    press(P_B4, 1);
    press(P_B7, 1);
    checks++;
    if (result !== 16'd99) $display("FAIL clr_setup: got %0d expected 99", result);
    else passes++;
    press(P_B9 | P_B5 | P_B1, 1);
    checks++;
    if ({one, two, three, four, result} !== 32'd0)
      $display("FAIL clr_regs: got %h expected 0", {one, two, three, four, result});
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h0000, 1'b0, 1'b0);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL clr_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
    press(P_B1, 1);
    checks++;
    if (result !== 16'd0) $display("FAIL clr_op_none: got %0d expected 0", result);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_v = exp_scan(tb_cnt[3:2], 16'h1000, 1'b0, 1'b0);
      checks++;
      if ({en, seg, dot} !== exp_v) $display("FAIL clr_digits_scan: got %b expected %b", {en, seg, dot}, exp_v);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    press(P_B2, 1);
    press(P_B5, 1);
    checks++;
    if (result !== 16'd11) $display("FAIL rstmid_setup: got %0d expected 11", result);
    else passes++;
    waited = 0;
    while (en === 4'b0111 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (en === 4'b0111) $display("FAIL rstmid_scan_wait: got en %b expected not 0111", en);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({en, seg, dot} !== {4'b0111, 7'b0000001, 1'b1})
      $display("FAIL rstmid_display: got %b expected %b", {en, seg, dot}, {4'b0111, 7'b0000001, 1'b1});
    else passes++;
    checks++;
    if ({one, two, three, four, result} !== 32'd0)
      $display("FAIL rstmid_regs: got %h expected 0", {one, two, three, four, result});
    else passes++;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 16'd0) $display("FAIL rstmid_after: got %0d expected 0", result);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_digit_wrap();
    test_add();
    test_sub_mul();
    test_mul_div();
    test_clear_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
